// File: rtl/pacman_vga_pkg.sv
// pacman_vga_pkg: shared VGA timing, tile-map constants and display region encoding
package pacman_vga_pkg;
  localparam logic [9:0] HD = 10'd640;
  localparam logic [9:0] VD = 10'd480;
  localparam int TILE_SHIFT = 4;
  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;
  localparam int TILE_AW = 11;
  typedef enum logic [1:0] {S_ACTIVE, S_HBLANK, S_VBLANK} region_t;
endpackage

// File: rtl/vram_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starting just after the last winner
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] pointer,
  input  logic                    enable,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] winner
);
  localparam int PW = $clog2(NREQ);
  int j;
  // scan from the farthest slot back toward pointer+1 so the nearest requester overrides
  always_comb begin
    grant = '0;
    winner = '0;
    j = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j = int'(pointer) + k;
      j = j >= NREQ ? j - NREQ : j;
      if (enable && req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        winner = PW'(j);
      end
    end
  end
endmodule

// File: rtl/vram_scheduler.sv
// vram_scheduler: shares the tile-map RAM port between display reads and round-robin writes (VRAM_VBLANK_ONLY_EN limits writes to vertical blanking)
module vram_scheduler
  import pacman_vga_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW = 4,
  parameter int AW = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              video_on,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]   gnt,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata,
  output logic [DW-1:0]     tile_code,
  output logic              tile_valid,
  output logic              frame_start,
  output logic [7:0]        frame_cnt
);
  localparam int PW = $clog2(NREQ);
  region_t state, state_nxt;
  logic [PW-1:0] ptr, win_idx;
  logic [NREQ-1:0] grant;
  logic win_open, any_gnt, vid_d, vb_entry;
  logic [9:0] xt, yt;
  logic [AW-1:0] disp_addr;
  assign xt = x >> TILE_SHIFT;
  assign yt = y >> TILE_SHIFT;
  assign disp_addr = (AW'(yt) << 5) + (AW'(yt) << 3) + AW'(xt);
`ifdef VRAM_VBLANK_ONLY_EN
  assign win_open = !video_on && y >= VD;
`else
  assign win_open = !video_on;
`endif
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req),
    .pointer(ptr),
    .enable(win_open && !reset),
    .grant(grant),
    .winner(win_idx)
  );
  assign gnt = grant;
  assign any_gnt = |grant;
  assign vb_entry = state_nxt == S_VBLANK && state != S_VBLANK;
  assign tile_code = tile_valid ? ram_rdata : '0;
  // classify the current inputs into a display region
  always_comb begin
    state_nxt = video_on ? S_ACTIVE : y >= VD ? S_VBLANK : S_HBLANK;
  end
  // region state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_ACTIVE;
    else state <= state_nxt;
  end
  // frame pacing: pulse and count on entry to vertical blanking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_start <= vb_entry;
      frame_cnt <= frame_cnt + 8'(vb_entry);
    end
  end
  // RAM command for next cycle: display read, granted write, or hold when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      ptr <= PW'(NREQ - 1);
    end else begin
      ram_we <= any_gnt;
      ram_addr <= video_on ? disp_addr : any_gnt ? wr_addr[win_idx*AW +: AW] : ram_addr;
      ram_wdata <= any_gnt ? wr_data[win_idx*DW +: DW] : ram_wdata;
      ptr <= any_gnt ? win_idx : ptr;
    end
  end
  // display valid trails video_on by the RAM address and read stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_d <= 1'b0;
      tile_valid <= 1'b0;
    end else begin
      vid_d <= video_on;
      tile_valid <= vid_d;
    end
  end
endmodule

// File: tb/tb_vram_scheduler.sv
// tb_vram_scheduler: directed stimulus with a cycle-level behavioural model and literal spot checks
module tb_vram_scheduler;
  localparam int NREQ = 4;
  localparam int DW = 4;
  localparam int AW = 11;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic video_on = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*AW-1:0] wr_addr = '0;
  logic [NREQ*DW-1:0] wr_data = '0;
  logic [NREQ-1:0] gnt;
  logic ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata, tile_code;
  logic tile_valid, frame_start;
  logic [7:0] frame_cnt;
  logic [DW-1:0] mem [2**AW];
  bit written [2**AW];
  int n_cmp = 0;
  int n_bad = 0;

  vram_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .req(req), .wr_addr(wr_addr), .wr_data(wr_data), .gnt(gnt),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .tile_code(tile_code), .tile_valid(tile_valid),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ 4'h5;
  endfunction

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return written[a] ? mem[a] : pat(a);
  endfunction

  // tile RAM: synchronous read-before-write, unwritten cells hold a fixed pattern
  always @(posedge clk) begin
    ram_rdata <= rd(ram_addr);
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model state
  int m_ptr = NREQ - 1;
  logic e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd = '0;
  logic e_fs = 1'b0;
  logic [7:0] e_fc = '0;
  logic in_vb = 1'b0;
  logic vq0 = 1'b0, vq1 = 1'b0;
  logic [AW-1:0] aq0 = '0, aq1 = '0;

  always @(negedge clk) begin
    int w;
    logic win, vb;
    logic [NREQ-1:0] eg;
    if (reset) begin
      m_ptr = NREQ - 1;
      e_we = 1'b0; e_addr = '0; e_wd = '0;
      e_fs = 1'b0; e_fc = '0; in_vb = 1'b0;
      vq0 = 1'b0; vq1 = 1'b0;
    end
    win = !reset && !video_on
`ifdef VRAM_VBLANK_ONLY_EN
      && y >= 10'd480
`endif
      ;
    w = -1;
    if (win)
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("frame_cnt", 32'(frame_cnt), 32'(e_fc));
    chk("tile_valid", 32'(tile_valid), 32'(vq1));
    chk("tile_code", 32'(tile_code), vq1 ? 32'(rd(aq1)) : 32'd0);
    if (!reset) begin
      vb = !video_on && y >= 10'd480;
      e_fs = vb && !in_vb;
      if (e_fs) e_fc++;
      in_vb = vb;
      vq1 = vq0; aq1 = aq0;
      vq0 = video_on;
      aq0 = AW'((y / 16) * 40 + x / 16);
      if (video_on) begin
        e_we = 1'b0;
        e_addr = aq0;
      end else if (w >= 0) begin
        e_we = 1'b1;
        e_addr = wr_addr[w*AW +: AW];
        e_wd = wr_data[w*DW +: DW];
        m_ptr = w;
      end else e_we = 1'b0;
    end
  end

  task automatic set_in(input int xx, input int yy, input logic v);
    x = 10'(xx);
    y = 10'(yy);
    video_on = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int xx, input int yy, input logic v);
    set_in(xx, yy, v);
    tick();
  endtask

  initial begin
    logic [NREQ-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tick();
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_fc", 32'(frame_cnt), 0);
    chk("rst_valid", 32'(tile_valid), 0);
    repeat (2) tick();
    reset = 1'b0;
    drive(32, 48, 1'b1);
    chk("rd_addr", 32'(ram_addr), 122);
    chk("rd_we", 32'(ram_we), 0);
    drive(48, 48, 1'b1);
    chk("rd_valid", 32'(tile_valid), 1);
    chk("rd_code", 32'(tile_code), 32'h8);
    req = 4'b0010;
    wr_addr[AW +: AW] = 11'd500;
    wr_data[DW +: DW] = 4'hA;
    for (int i = 600; i < 639; i++) drive(i, 100, 1'b1);
    set_in(639, 100, 1'b1);
    #1 chk("wr_gnt_active", 32'(gnt), 0);
    tick();
    set_in(640, 100, 1'b0);
    #1 chk("wr_gnt_640", 32'(gnt), 32'b0010);
    tick();
    req = '0;
    chk("wr_we", 32'(ram_we), 1);
    chk("wr_addr", 32'(ram_addr), 500);
    chk("wr_data", 32'(ram_wdata), 32'hA);
    for (int i = 641; i < 800; i++) drive(i, 100, 1'b0);
    reset = 1'b1;
    req = 4'b1111;
    set_in(640, 101, 1'b0);
    #1 chk("rst_gnt_forced", 32'(gnt), 0);
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_in(640 + k, 101, 1'b0);
      #1 chk("rr_seq", 32'(gnt), 32'(seq[k]));
      tick();
    end
    req = 4'b0001;
    wr_addr[0 +: AW] = 11'd77;
    wr_data[0 +: DW] = 4'h3;
    set_in(799, 199, 1'b0);
    #1 chk("mid_gnt", 32'(gnt), 1);
    tick();
    reset = 1'b1;
    set_in(300, 200, 1'b1);
    #1 chk("mid_rst_we", 32'(ram_we), 0);
    chk("mid_rst_addr", 32'(ram_addr), 0);
    chk("mid_rst_wdata", 32'(ram_wdata), 0);
    tick();
    set_in(700, 200, 1'b0);
    #1 chk("mid_rst_gnt", 32'(gnt), 0);
    tick();
    reset = 1'b0;
    #1 chk("rearb_gnt", 32'(gnt), 1);
    tick();
    req = '0;
    chk("rearb_we", 32'(ram_we), 1);
    chk("rearb_addr", 32'(ram_addr), 77);
    drive(0, 479, 1'b1);
    drive(0, 480, 1'b0);
    chk("fs_pulse", 32'(frame_start), 1);
    chk("fc_one", 32'(frame_cnt), 1);
    drive(1, 480, 1'b0);
    chk("fs_drop", 32'(frame_start), 0);
    chk("fc_hold", 32'(frame_cnt), 1);
    for (int f = 1; f < 256; f++) begin
      drive(0, 479, 1'b1);
      drive(0, 480, 1'b0);
    end
    chk("fc_wrap", 32'(frame_cnt), 0);
    req = 4'b0001;
    set_in(700, 10, 1'b0);
`ifdef VRAM_VBLANK_ONLY_EN
    #1 chk("vbo_hblank_gnt", 32'(gnt), 0);
`else
    #1 chk("hblank_gnt", 32'(gnt), 1);
`endif
    tick();
    for (int yy = 11; yy < 480; yy++) begin
      drive(0, yy, 1'b1);
      drive(639, yy, 1'b1);
      drive(640, yy, 1'b0);
      drive(799, yy, 1'b0);
    end
    set_in(0, 480, 1'b0);
    #1 chk("vblank_gnt", 32'(gnt), 1);
    tick();
    req = '0;
    repeat (4) drive(1, 480, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish by %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
